// File: rtl/apb_master_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types for the APB master bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_REJECT = 2'd3
    } apb_mst_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge_if
// Description : Core request/response and APB bus signals of the bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    req_i;
    logic [ADDR_WIDTH-1:0]   addr_i;
    logic                    we_i;
    logic [DATA_WIDTH/8-1:0] be_i;
    logic [DATA_WIDTH-1:0]   wdata_i;
    logic                    gnt_o;
    logic                    rvalid_o;
    logic [DATA_WIDTH-1:0]   rdata_o;
    logic                    err_o;
    logic [ADDR_WIDTH-1:0]   paddr_o;
    logic [DATA_WIDTH-1:0]   pwdata_o;
    logic                    pwrite_o;
    logic                    psel_o;
    logic                    penable_o;
    logic [DATA_WIDTH-1:0]   prdata_i;
    logic                    pready_i;
    logic                    pslverr_i;

    // The bridge itself
    modport master (
        input  req_i, addr_i, we_i, be_i, wdata_i, prdata_i, pready_i, pslverr_i,
        output gnt_o, rvalid_o, rdata_o, err_o, paddr_o, pwdata_o, pwrite_o,
               psel_o, penable_o
    );

    // Core plus APB slave environment around the bridge
    modport slave (
        output req_i, addr_i, we_i, be_i, wdata_i, prdata_i, pready_i, pslverr_i,
        input  gnt_o, rvalid_o, rdata_o, err_o, paddr_o, pwdata_o, pwrite_o,
               psel_o, penable_o
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_bridge_wdog.sv
`default_nettype none
// ============================================================================
// Module      : apb_watchdog_cnt
// Description : ACCESS-phase wait counter; flags the last permitted cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_watchdog_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  wire logic clk_i,
    input  wire logic rst_ni,
    input  wire logic clear_i,
    input  wire logic en_i,
    output logic      limit_o
);
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            logic unused_ok;
            assign unused_ok = ^{clk_i, rst_ni, clear_i, en_i};
            assign limit_o   = 1'b0;
        end else begin : g_enabled
            localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                end else if (clear_i) begin
                    cnt_q <= '0;
                end else if (en_i) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            // High in the ACCESS cycle whose stall would bring the count to the limit
            assign limit_o = (cnt_q == LIMIT);
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge
// Description : Core req/gnt/rvalid to APB3 initiator, one transfer at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  wire logic            clk_i,
    input  wire logic            rst_ni,
    apb_master_bridge_if.master  bus
);
    apb_mst_state_e              state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                        pwrite_q, pwrite_d;
    logic                        rvalid_q, rvalid_d;
    logic [APB_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                        err_q, err_d;
    logic                        gnt, psel, penable;
    logic                        wd_clear, wd_en, wd_limit;

    apb_watchdog_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (wd_clear),
        .en_i    (wd_en),
        .limit_o (wd_limit)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        gnt      = 1'b0;
        psel     = 1'b0;
        penable  = 1'b0;
        wd_clear = 1'b0;
        wd_en    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                gnt = bus.req_i;
                if (bus.req_i) begin
                    // Partial writes never reach the bus; APB registers keep old values
                    if (bus.we_i && (bus.be_i != '1)) begin
                        state_d = ST_REJECT;
                    end else begin
                        paddr_d  = bus.addr_i;
                        pwdata_d = bus.wdata_i;
                        pwrite_d = bus.we_i;
                        state_d  = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                psel     = 1'b1;
                wd_clear = 1'b1;
                state_d  = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                wd_en   = !bus.pready_i;
                if (bus.pready_i) begin
                    rvalid_d = 1'b1;
                    rdata_d  = pwrite_q ? '0 : bus.prdata_i;
                    err_d    = bus.pslverr_i;
                    state_d  = ST_IDLE;
                end else if (wd_limit) begin
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_REJECT: begin
                rvalid_d = 1'b1;
                rdata_d  = '0;
                err_d    = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.gnt_o     = gnt;
    assign bus.psel_o    = psel;
    assign bus.penable_o = penable;
    assign bus.paddr_o   = paddr_q;
    assign bus.pwdata_o  = pwdata_q;
    assign bus.pwrite_o  = pwrite_q;
    assign bus.rvalid_o  = rvalid_q;
    assign bus.rdata_o   = rdata_q;
    assign bus.err_o     = err_q;
endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_bridge
// Description : Directed self-checking bench for apb_master_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    apb_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_master_bridge #(
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .TIMEOUT_CYCLES (4)
    ) u_dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.master)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start a new cycle: inputs change just after the rising edge
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic drive_req(input logic [31:0] a, input logic w, input logic [3:0] be,
                             input logic [31:0] wd);
        bus.req_i   = 1'b1;
        bus.addr_i  = a;
        bus.we_i    = w;
        bus.be_i    = be;
        bus.wdata_i = wd;
    endtask

    initial begin
        bus.req_i     = 1'b0;
        bus.addr_i    = '0;
        bus.we_i      = 1'b0;
        bus.be_i      = '0;
        bus.wdata_i   = '0;
        bus.prdata_i  = '0;
        bus.pready_i  = 1'b0;
        bus.pslverr_i = 1'b0;

        // Reset state
        smp();
        chk("rst_psel", bus.psel_o, 0);
        chk("rst_penable", bus.penable_o, 0);
        chk("rst_rvalid", bus.rvalid_o, 0);
        chk("rst_rdata", bus.rdata_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_paddr", bus.paddr_o, 0);
        cyc(); rst_ni = 1'b1;

        // Read, zero-wait slave
        cyc(); drive_req(32'h1A10_0004, 1'b0, 4'h0, 32'h0);
        bus.pready_i = 1'b1; bus.prdata_i = 32'hDEAD_BEEF;
        smp(); chk("rd_gnt", bus.gnt_o, 1); chk("rd_psel_n", bus.psel_o, 0);
        cyc(); bus.req_i = 1'b0;
        smp(); chk("rd_setup_psel", bus.psel_o, 1); chk("rd_setup_pen", bus.penable_o, 0);
        chk("rd_paddr", bus.paddr_o, 32'h1A10_0004); chk("rd_pwrite", bus.pwrite_o, 0);
        chk("rd_setup_gnt", bus.gnt_o, 0);
        cyc(); smp(); chk("rd_acc_psel", bus.psel_o, 1); chk("rd_acc_pen", bus.penable_o, 1);
        chk("rd_acc_rvalid", bus.rvalid_o, 0);
        cyc(); smp(); chk("rd_rvalid", bus.rvalid_o, 1); chk("rd_rdata", bus.rdata_o, 32'hDEAD_BEEF);
        chk("rd_err", bus.err_o, 0); chk("rd_done_psel", bus.psel_o, 0);
        cyc(); smp(); chk("rd_rvalid_1cyc", bus.rvalid_o, 0); chk("rd_rdata_hold", bus.rdata_o, 32'hDEAD_BEEF);

        // Write with three wait states
        cyc(); drive_req(32'h1A10_0008, 1'b1, 4'hF, 32'h1234_5678); bus.pready_i = 1'b0;
        smp(); chk("wr_gnt", bus.gnt_o, 1);
        cyc(); bus.req_i = 1'b0;
        smp(); chk("wr_setup_psel", bus.psel_o, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(); smp();
            chk("wr_wait_pen", bus.penable_o, 1); chk("wr_wait_paddr", bus.paddr_o, 32'h1A10_0008);
            chk("wr_wait_pwdata", bus.pwdata_o, 32'h1234_5678); chk("wr_wait_pwrite", bus.pwrite_o, 1);
            chk("wr_wait_rvalid", bus.rvalid_o, 0);
        end
        cyc(); bus.pready_i = 1'b1; bus.prdata_i = 32'hFFFF_FFFF;
        smp(); chk("wr_last_pen", bus.penable_o, 1); chk("wr_last_pwdata", bus.pwdata_o, 32'h1234_5678);
        cyc(); smp(); chk("wr_rvalid", bus.rvalid_o, 1); chk("wr_err", bus.err_o, 0);
        chk("wr_rdata_zero", bus.rdata_o, 0); chk("wr_done_psel", bus.psel_o, 0);

        // Partial write rejected locally
        cyc(); drive_req(32'h0000_0022, 1'b1, 4'b0011, 32'hAAAA_5555);
        smp(); chk("pw_gnt", bus.gnt_o, 1); chk("pw_rvalid_n", bus.rvalid_o, 0);
        cyc(); bus.req_i = 1'b0;
        smp(); chk("pw_psel", bus.psel_o, 0); chk("pw_rvalid_early", bus.rvalid_o, 0);
        chk("pw_paddr_keep", bus.paddr_o, 32'h1A10_0008); chk("pw_pwdata_keep", bus.pwdata_o, 32'h1234_5678);
        cyc(); smp(); chk("pw_rvalid", bus.rvalid_o, 1); chk("pw_err", bus.err_o, 1);
        chk("pw_rdata", bus.rdata_o, 0); chk("pw_psel_after", bus.psel_o, 0);

        // Slave error, then back-to-back request granted in the rvalid cycle
        cyc(); drive_req(32'h0000_0030, 1'b0, 4'h0, 32'h0);
        bus.pready_i = 1'b1; bus.pslverr_i = 1'b1; bus.prdata_i = 32'h0000_0055;
        smp(); chk("se_gnt", bus.gnt_o, 1);
        cyc(); bus.req_i = 1'b0;
        cyc(); smp(); chk("se_acc_pen", bus.penable_o, 1);
        cyc(); drive_req(32'h0000_0034, 1'b0, 4'h0, 32'h0);
        bus.pslverr_i = 1'b0; bus.prdata_i = 32'h0000_0066;
        smp(); chk("se_rvalid", bus.rvalid_o, 1); chk("se_err", bus.err_o, 1);
        chk("se_rdata", bus.rdata_o, 32'h55); chk("b2b_gnt", bus.gnt_o, 1);
        cyc(); bus.req_i = 1'b0;
        smp(); chk("b2b_setup_psel", bus.psel_o, 1); chk("b2b_paddr", bus.paddr_o, 32'h34);
        chk("b2b_rvalid_n", bus.rvalid_o, 0);
        cyc(); cyc(); smp(); chk("b2b_rvalid", bus.rvalid_o, 1); chk("b2b_err", bus.err_o, 0);
        chk("b2b_rdata", bus.rdata_o, 32'h66);

        // Watchdog timeout with pready held low
        cyc(); drive_req(32'h0000_0040, 1'b0, 4'h0, 32'h0); bus.pready_i = 1'b0;
        cyc(); bus.req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(); smp(); chk("to_pen", bus.penable_o, 1); chk("to_rvalid_n", bus.rvalid_o, 0);
        end
        cyc(); smp(); chk("to_psel_drop", bus.psel_o, 0); chk("to_pen_drop", bus.penable_o, 0);
        chk("to_rvalid", bus.rvalid_o, 1); chk("to_err", bus.err_o, 1); chk("to_rdata", bus.rdata_o, 0);

        // pready on the limit cycle wins over the watchdog
        cyc(); drive_req(32'h0000_0044, 1'b0, 4'h0, 32'h0); bus.prdata_i = 32'h0000_0077;
        cyc(); bus.req_i = 1'b0;
        cyc(); cyc(); cyc();
        cyc(); bus.pready_i = 1'b1;
        smp(); chk("tl_pen_4th", bus.penable_o, 1); chk("tl_rvalid_n", bus.rvalid_o, 0);
        cyc(); smp(); chk("tl_rvalid", bus.rvalid_o, 1); chk("tl_err", bus.err_o, 0);
        chk("tl_rdata", bus.rdata_o, 32'h77);

        // Reset during ACCESS
        cyc(); drive_req(32'h0000_0050, 1'b0, 4'h0, 32'h0); bus.pready_i = 1'b0;
        cyc(); bus.req_i = 1'b0;
        cyc(); smp(); chk("ra_pen", bus.penable_o, 1);
        cyc(); rst_ni = 1'b0;
        #1; chk("ra_psel_async", bus.psel_o, 0); chk("ra_pen_async", bus.penable_o, 0);
        chk("ra_rdata_rst", bus.rdata_o, 0);
        cyc(); rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp(); chk("ra_no_rvalid", bus.rvalid_o, 0); chk("ra_psel_idle", bus.psel_o, 0);
            cyc();
        end
        drive_req(32'h0000_0060, 1'b0, 4'h0, 32'h0);
        bus.pready_i = 1'b1; bus.prdata_i = 32'h0BAD_F00D;
        smp(); chk("ra_new_gnt", bus.gnt_o, 1);
        cyc(); bus.req_i = 1'b0;
        cyc(); cyc(); smp(); chk("ra_new_rvalid", bus.rvalid_o, 1);
        chk("ra_new_rdata", bus.rdata_o, 32'h0BAD_F00D); chk("ra_new_err", bus.err_o, 0);

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Initiator end of the APB subsystem. Converts the core-side request/grant/rvalid memory protocol into single APB3 transfers (SETUP then ACCESS).
- Drives the slave port of the APB node. One transfer outstanding at a time.
- A configurable watchdog terminates a hung transfer with an error.
- Partial-width writes are rejected locally.

Parameters:
- APB_ADDR_WIDTH, 32, address width on both sides.
- APB_DATA_WIDTH, 32, data width on both sides; must be a multiple of 8.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before forced error; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  core request.
- addr_i  in  APB_ADDR_WIDTH  request address.
- we_i  in  1  1=write, 0=read.
- be_i  in  APB_DATA_WIDTH/8  byte enables.
- wdata_i  in  APB_DATA_WIDTH  write data.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  response valid (single cycle).
- rdata_o  out  APB_DATA_WIDTH  read data.
- err_o  out  1  response error, qualified by rvalid_o.
- paddr_o  out  APB_ADDR_WIDTH  APB address.
- pwdata_o  out  APB_DATA_WIDTH  APB write data.
- pwrite_o  out  1  APB direction.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- prdata_i  in  APB_DATA_WIDTH  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low on rst_ni. During reset all registered outputs are 0 and the FSM is IDLE.
  - Reset is synchronously released by the surrounding logic.
- FSM states: IDLE, SETUP, ACCESS, REJECT.
- IDLE:
  - gnt_o = req_i (combinational); gnt_o is 0 in every other state.
  - On req_i, capture addr_i into paddr_o, wdata_i into pwdata_o and we_i into pwrite_o.
  - Next state is SETUP, unless we_i=1 and be_i is not all-ones, in which case next state is REJECT and paddr/pwdata/pwrite keep their old values.
- SETUP: psel_o=1, penable_o=0; lasts one cycle, then ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1.
  - paddr/pwdata/pwrite are stable for the whole transfer.
  - When pready_i=1: capture prdata_i (reads only; writes return 0) and pslverr_i. Next cycle rvalid_o=1 with rdata_o/err_o. State returns to IDLE.
- REJECT: no APB activity; next cycle rvalid_o=1, err_o=1, rdata_o=0; state returns to IDLE.
- Output timing:
  - rvalid_o, rdata_o and err_o are registered.
  - rvalid_o is high exactly one cycle per grant.
  - rdata_o/err_o hold until the next response; reset value 0.
- Latency:
  - Request granted in cycle N; SETUP in N+1; ACCESS from N+2.
  - With pready_i=1 at N+2, rvalid_o is high at N+3.
  - A new request may be granted in N+3 (the IDLE cycle coinciding with rvalid_o). Back-to-back throughput is one transfer per 3 cycles.
- Watchdog:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with pready_i=0.
  - When it reaches TIMEOUT_CYCLES and pready_i=0, drop psel_o/penable_o the next cycle, return to IDLE, and raise rvalid_o=1, err_o=1, rdata_o=0.
  - If pready_i=1 arrives in the same cycle the limit is reached, the normal completion wins.
- APB signals between transfers:
  - psel_o=0 and penable_o=0 outside SETUP/ACCESS.
  - paddr/pwdata/pwrite hold their last values.
- Reset mid-transfer:
  - psel_o and penable_o drop asynchronously and the FSM returns to IDLE.
  - No rvalid_o is issued for the aborted request.
- Reads ignore be_i. A write with all-ones be_i uses the normal APB path.

Decomposition:
- apb_pkg: FSM state enum (apb_mst_state_e).
- One sub-module, apb_watchdog_cnt: clear, enable, limit-reached output, TIMEOUT_CYCLES parameter, with a constant-0 output when TIMEOUT_CYCLES=0.

Test Plan:
- Read, zero-wait slave: req at addr 0x1A10_0004, pready tied 1, prdata=0xDEAD_BEEF -> gnt at N; psel N+1..N+2; penable N+2; rvalid N+3 with rdata=0xDEAD_BEEF, err=0.
- Write with wait states: we=1, be=4'hF, wdata=0x1234_5678, pready low 3 ACCESS cycles -> paddr/pwdata/pwrite stable for 4 ACCESS cycles; rvalid one cycle after pready with err=0.
- Partial write: we=1, be=4'b0011 -> gnt, psel never asserted, rvalid next cycle with err=1, rdata=0.
- Slave error: read, pready=1 with pslverr=1 -> rvalid with err=1; a back-to-back second request is granted in the rvalid cycle.
- Timeout: TIMEOUT_CYCLES=4, pready held 0 -> penable high 4 cycles, then psel/penable drop; rvalid with err=1, rdata=0. Repeat with pready=1 on the 4th cycle -> normal completion, err=0.
- Reset in ACCESS: assert rst_ni=0 mid-wait -> psel/penable 0 immediately, no rvalid; after release, a new read completes normally.
